// File: rtl/fabric_op_pkg.sv
// Shared types and constants for the fabric operation sequencer.
package fabric_op_pkg;

    localparam int DATA_W     = 32;
    localparam int LANE_W     = 4;
    localparam int SEND_BEATS = 8;
    localparam int RES_BEATS  = 3;
    localparam int RES_W      = 12;
    localparam int BEAT_W     = $clog2(SEND_BEATS);
    localparam int TIMER_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/fabric_op_timer.sv
// WAIT-phase timeout counter: counts idle WAIT cycles and flags the cycle on which
// the count reaches TIMEOUT_CYCLES.
module fabric_op_timer
    import fabric_op_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the idle cycle that would take the count to TIMEOUT_CYCLES.
    assign expired = enable && !clear && (count_q == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fabric_op_seq.sv
// Fabric operation sequencer: streams two operand words out as nibble beats and
// assembles a three-beat result. WAIT timeout is built only with FABRIC_OP_TIMEOUT_EN.
module fabric_op_seq
    import fabric_op_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [DATA_W-1:0] cpu_opa,
    input  logic [DATA_W-1:0] cpu_opb,
    output logic              cpu_rsp_valid,
    input  logic              cpu_rsp_ready,
    output logic [DATA_W-1:0] cpu_rsp_data,
    output logic              cpu_rsp_err,
    output logic [LANE_W-1:0] opa_o,
    output logic [LANE_W-1:0] opb_o,
    output logic              fab_strobe,
    input  logic [RES_W-1:0]  res_i,
    input  logic              fab_done
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                accept;
    logic                in_send;
    logic                in_wait;
    logic                capture;
    logic                timeout_hit;
    logic [LANE_W-1:0]   opa_lane [SEND_BEATS];
    logic [LANE_W-1:0]   opb_lane [SEND_BEATS];

    assign in_send       = (state_q == SEND);
    assign in_wait       = (state_q == WAIT);
    assign cpu_req_ready = resetn && (state_q == IDLE);
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign capture       = in_wait && fab_done;

    genvar gi;
    generate
        for (gi = 0; gi < SEND_BEATS; gi++) begin : g_lane
            assign opa_lane[gi] = opa_q[gi*LANE_W +: LANE_W];
            assign opb_lane[gi] = opb_q[gi*LANE_W +: LANE_W];
        end
    endgenerate

`ifdef FABRIC_OP_TIMEOUT_EN
    logic err_q, err_d;

    fabric_op_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .CLK    (CLK),
        .resetn (resetn),
        .clear  (!in_wait || capture),
        .enable (in_wait && !fab_done),
        .expired(timeout_hit)
    );

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (in_wait && !fab_done && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cpu_rsp_err = cpu_rsp_valid && err_q;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign cpu_rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    beat_d  = '0;
                    opa_d   = cpu_opa;
                    opb_d   = cpu_opb;
                end
            end
            SEND: begin
                if (beat_q == BEAT_W'(SEND_BEATS - 1)) begin
                    state_d = WAIT;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            WAIT: begin
                if (fab_done) begin
                    // Last beat carries only the top byte; res_i[11:8] is dropped there.
                    if (beat_q == BEAT_W'(0)) begin
                        data_d[11:0] = res_i;
                    end else if (beat_q == BEAT_W'(1)) begin
                        data_d[23:12] = res_i;
                    end else begin
                        data_d[31:24] = res_i[7:0];
                    end
                    if (beat_q == BEAT_W'(RES_BEATS - 1)) begin
                        state_d = RESP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = RESP;
                    beat_d  = '0;
                    data_d  = '0;
                end
            end
            RESP: begin
                if (cpu_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            data_q  <= data_d;
        end
    end

    assign fab_strobe    = in_send;
    assign opa_o         = in_send ? opa_lane[beat_q] : '0;
    assign opb_o         = in_send ? opb_lane[beat_q] : '0;
    assign cpu_rsp_valid = (state_q == RESP);
    assign cpu_rsp_data  = cpu_rsp_valid ? data_q : '0;

endmodule

// File: tb/tb_fabric_op_seq.sv
// Timeline-planned bench: every transaction is scheduled up front, producing per-cycle
// input drives and expected outputs; a compare process checks the DUT each cycle.
module tb_fabric_op_seq;

    localparam int MAXC = 4000;
`ifdef FABRIC_OP_TIMEOUT_EN
    localparam int TO         = 4;
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam int TO         = 255;
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int F_OPA = 0, F_OPB = 1, F_STB = 2, F_RV = 3, F_DATA = 4, F_ERR = 5, F_RDY = 6;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_opa, cpu_opb;
    logic        cpu_rsp_valid;
    logic        cpu_rsp_ready;
    logic [31:0] cpu_rsp_data;
    logic        cpu_rsp_err;
    logic [3:0]  opa_o, opb_o;
    logic        fab_strobe;
    logic [11:0] res_i;
    logic        fab_done;

    fabric_op_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_opa      (cpu_opa),
        .cpu_opb      (cpu_opb),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_ready(cpu_rsp_ready),
        .cpu_rsp_data (cpu_rsp_data),
        .cpu_rsp_err  (cpu_rsp_err),
        .opa_o        (opa_o),
        .opb_o        (opb_o),
        .fab_strobe   (fab_strobe),
        .res_i        (res_i),
        .fab_done     (fab_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Planned timeline: expected outputs and input drives, per cycle.
    logic        exp_rdy [MAXC];
    logic        exp_stb [MAXC];
    logic        exp_rv  [MAXC];
    logic        exp_err [MAXC];
    logic [3:0]  exp_a   [MAXC];
    logic [3:0]  exp_b   [MAXC];
    logic [31:0] exp_d   [MAXC];
    logic        d_val   [MAXC];
    logic        d_done  [MAXC];
    logic        d_rr    [MAXC];
    logic        d_rst   [MAXC];
    logic        d_pulse [MAXC];
    logic        busy    [MAXC];
    logic [31:0] d_opa   [MAXC];
    logic [31:0] d_opb   [MAXC];
    logic [11:0] d_res   [MAXC];

    typedef struct {
        int          c;
        int          f;
        logic [31:0] v;
    } pin_t;
    pin_t pins[$];

    int last_cyc = MAXC;
    int n_chk    = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic add_pin(input int c, input int f, input logic [31:0] v);
        pin_t p;
        p.c = c; p.f = f; p.v = v;
        pins.push_back(p);
    endtask

    // Schedule one operation accepted at cycle t0. Gaps are idle WAIT cycles before each
    // result beat; hold is the number of RESP cycles with cpu_rsp_ready low.
    task automatic plan_txn(input int t0, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic [3:0] hi,
                            input int g0, input int g1, input int g2, input int hold,
                            input int rst_beat, output int nxt);
        int          gap [3];
        int          dcs [3];
        logic [11:0] beat [3];
        int          s, r0, nb;
        logic        err;
        logic [31:0] dat;
        gap[0] = g0; gap[1] = g1; gap[2] = g2;
        beat[0] = r[11:0];
        beat[1] = r[23:12];
        beat[2] = {hi, r[31:24]};
        d_val[t0] = 1'b1;
        d_opa[t0] = a;
        d_opb[t0] = b;
        for (int k = 0; k < 8; k++) begin
            automatic int c = t0 + 1 + k;
            if (k == rst_beat) begin
                d_pulse[c] = 1'b1;
                exp_rdy[c] = 1'b0;
                nxt = c + 1;
                return;
            end
            busy[c]    = 1'b1;
            exp_rdy[c] = 1'b0;
            exp_stb[c] = 1'b1;
            exp_a[c]   = a[4*k +: 4];
            exp_b[c]   = b[4*k +: 4];
        end
        s = t0 + 9; err = 1'b0; nb = 0;
        for (int i = 0; i < 3; i++) begin
            if (TIMEOUT_EN && gap[i] >= TO) begin
                err = 1'b1;
                break;
            end
            dcs[i] = s + gap[i];
            s = dcs[i] + 1;
            nb++;
        end
        r0 = err ? s + TO : s;
        for (int c = t0 + 9; c < r0; c++) begin
            busy[c] = 1'b1; exp_rdy[c] = 1'b0; d_done[c] = 1'b0;
        end
        for (int i = 0; i < nb; i++) begin
            d_done[dcs[i]] = 1'b1;
            d_res[dcs[i]]  = beat[i];
        end
        dat = err ? 32'h0 : r;
        for (int c = r0; c <= r0 + hold; c++) begin
            busy[c] = 1'b1; exp_rdy[c] = 1'b0; exp_rv[c] = 1'b1;
            exp_d[c] = dat; exp_err[c] = err; d_rr[c] = (c == r0 + hold);
        end
        nxt = r0 + hold + 1;
    endtask

    function automatic logic [31:0] field_val(input int f);
        case (f)
            F_OPA:   return {28'h0, opa_o};
            F_OPB:   return {28'h0, opb_o};
            F_STB:   return {31'h0, fab_strobe};
            F_RV:    return {31'h0, cpu_rsp_valid};
            F_DATA:  return cpu_rsp_data;
            F_ERR:   return {31'h0, cpu_rsp_err};
            default: return {31'h0, cpu_req_ready};
        endcase
    endfunction

    // Input driver: applies the planned drives just after each rising edge.
    initial begin
        resetn = 1'b0; cpu_req_valid = 1'b0; cpu_opa = '0; cpu_opb = '0;
        cpu_rsp_ready = 1'b0; res_i = '0; fab_done = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (cyc < MAXC) begin
                resetn        = d_rst[cyc];
                cpu_req_valid = d_val[cyc];
                cpu_opa       = d_opa[cyc];
                cpu_opb       = d_opb[cyc];
                cpu_rsp_ready = d_rr[cyc];
                res_i         = d_res[cyc];
                fab_done      = d_done[cyc];
                if (d_pulse[cyc]) begin
                    #2;
                    resetn = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge CLK) begin
        if (cyc < last_cyc) begin
            n_chk++;
            if (cpu_req_ready !== exp_rdy[cyc] || fab_strobe !== exp_stb[cyc] ||
                opa_o !== exp_a[cyc] || opb_o !== exp_b[cyc] || cpu_rsp_valid !== exp_rv[cyc] ||
                cpu_rsp_data !== exp_d[cyc] || cpu_rsp_err !== exp_err[cyc]) begin
                $display("FAIL cycle %0d outputs: got rdy=%b stb=%b a=%h b=%h v=%b d=%h e=%b, want rdy=%b stb=%b a=%h b=%h v=%b d=%h e=%b",
                         cyc, cpu_req_ready, fab_strobe, opa_o, opb_o, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_err,
                         exp_rdy[cyc], exp_stb[cyc], exp_a[cyc], exp_b[cyc], exp_rv[cyc], exp_d[cyc], exp_err[cyc]);
            end else begin
                n_pass++;
            end
            foreach (pins[i]) begin
                if (pins[i].c == cyc) begin
                    n_chk++;
                    if (field_val(pins[i].f) !== pins[i].v) begin
                        $display("FAIL pin cycle %0d field %0d: got %h want %h",
                                 cyc, pins[i].f, field_val(pins[i].f), pins[i].v);
                    end else begin
                        n_pass++;
                    end
                end
            end
            if (cpu_rsp_valid && cpu_rsp_ready) begin
                n_txn++;
                $display("txn %0d: cycle %0d data=%h err=%b", n_txn, cyc, cpu_rsp_data, cpu_rsp_err);
            end
        end
    end

    initial begin
        int nxt, t;
        for (int c = 0; c < MAXC; c++) begin
            exp_rdy[c] = 1'b1; exp_stb[c] = 1'b0; exp_rv[c] = 1'b0; exp_err[c] = 1'b0;
            exp_a[c] = '0; exp_b[c] = '0; exp_d[c] = '0;
            d_val[c] = 1'b0; d_done[c] = 1'($urandom); d_rr[c] = 1'($urandom);
            d_rst[c] = 1'b1; d_pulse[c] = 1'b0; busy[c] = 1'b0;
            d_opa[c] = $urandom; d_opb[c] = $urandom; d_res[c] = 12'($urandom);
        end
        for (int c = 0; c < 4; c++) begin
            d_rst[c] = 1'b0; exp_rdy[c] = 1'b0;
        end
        add_pin(2, F_RDY, 32'h0);
        add_pin(4, F_RDY, 32'h1);

        // Reference operation: minimum latency.
        t = 6;
        plan_txn(t, 32'h87654321, 32'hFEDCBA98, 32'h87654321, 4'h0, 0, 0, 0, 0, -1, nxt);
        add_pin(t + 1, F_OPA, 32'h1);  add_pin(t + 1, F_OPB, 32'h8);
        add_pin(t + 4, F_OPA, 32'h4);  add_pin(t + 4, F_OPB, 32'hB);
        add_pin(t + 8, F_OPA, 32'h8);  add_pin(t + 8, F_OPB, 32'hF);
        add_pin(t + 9, F_STB, 32'h0);  add_pin(t + 11, F_RV, 32'h0);
        add_pin(t + 12, F_RV, 32'h1);  add_pin(t + 12, F_DATA, 32'h87654321);
        add_pin(t + 12, F_ERR, 32'h0); add_pin(t + 13, F_RDY, 32'h1);

        // Gapped beats at +10, +15, +20 with the response held for 5 cycles.
        t = nxt + 1;
        plan_txn(t, 32'h87654321, 32'hFEDCBA98, 32'h87654321, 4'h0, 1, 4, 4, 5, -1, nxt);
        add_pin(nxt - 1, F_RDY, 32'h0); add_pin(nxt - 1, F_RV, 32'h1);
        add_pin(nxt, F_RDY, 32'h1);     add_pin(nxt, F_RV, 32'h0);

        // Long silence before the first beat (times out when the timeout is built).
        t = nxt + 2;
        plan_txn(t, $urandom, $urandom, $urandom, 4'($urandom), 20, 0, 0, 1, -1, nxt);

        // Asynchronous reset during SEND beat 3, then a clean operation.
        t = nxt;
        plan_txn(t, 32'h13572468, 32'h0F0F0F0F, $urandom, 4'hA, 0, 0, 0, 0, 3, nxt);
        add_pin(t + 4, F_OPA, 32'h0); add_pin(t + 4, F_STB, 32'h0);
        add_pin(t + 5, F_RDY, 32'h1);
        t = nxt + 1;
        plan_txn(t, 32'h87654321, 32'hFEDCBA98, 32'h87654321, 4'h5, 0, 0, 0, 0, -1, nxt);
        add_pin(t + 12, F_DATA, 32'h87654321);

        for (int n = 0; n < 40; n++) begin
            t = nxt + int'($urandom_range(0, 3));
            plan_txn(t, $urandom, $urandom, $urandom, 4'($urandom),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 4)), (n % 10 == 7) ? int'($urandom_range(0, 7)) : -1, nxt);
        end
        for (int c = 0; c < MAXC; c++) begin
            if (busy[c]) d_val[c] = 1'($urandom);
        end
        last_cyc = nxt + 4;

        wait (cyc >= last_cyc);
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
